// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : Resets the PLL, waits for stable lock, releases the downstream reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int LOCK_STABLE_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       locked,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic       pll_fail
);

    localparam int c_max_ab = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int c_max    = (c_max_ab > LOCK_STABLE_CYCLES) ? c_max_ab : LOCK_STABLE_CYCLES;
    localparam int c_cnt_w  = $clog2(c_max) + 1;

    localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stb_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] S_PLLRST = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STABLE = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_pll_reset;
    logic               r_sys_rst_n;
    logic               r_ready;
    logic [3:0]         r_retry;
    logic [7:0]         r_loss;
    logic               r_fail;

    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [3:0]         w_retry_nxt;
    logic [7:0]         w_loss_nxt;
    logic               w_pll_reset_nxt;
    logic               w_run_nxt;
    logic               w_fail_nxt;
    logic               w_lock_s;

    assign w_lock_s = r_sync2;

    // Every output is a flop loaded from the next-state decode, so outputs
    // move on the same edge as the state and pll_lock never reaches them combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_PLLRST;
            r_cnt       <= '0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_retry     <= 4'd0;
            r_loss      <= 8'd0;
            r_fail      <= 1'b0;
        end else begin
            r_sync1     <= pll_lock;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pll_reset <= w_pll_reset_nxt;
            r_sys_rst_n <= w_run_nxt;
            r_ready     <= w_run_nxt;
            r_retry     <= w_retry_nxt;
            r_loss      <= w_loss_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        case (r_state)
            S_PLLRST: begin
                if (r_cnt == c_rst_last) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            S_WAIT: begin
                // Lock wins over a timeout landing on the same cycle.
                if (w_lock_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_to_last) begin
                    w_state_nxt = S_PLLRST;
                    w_cnt_nxt   = '0;
                    if (r_retry != 4'hF) begin
                        w_retry_nxt = r_retry + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stb_last) begin
                    w_state_nxt = S_RUN;
                    w_retry_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_PLLRST;
                    w_cnt_nxt   = '0;
                    if (r_loss != 8'hFF) begin
                        w_loss_nxt = r_loss + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_PLLRST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_pll_reset_nxt = (w_state_nxt == S_PLLRST);
        w_run_nxt       = (w_state_nxt == S_RUN);
        w_fail_nxt      = (w_retry_nxt == 4'hF);
    end

    assign pll_reset       = r_pll_reset;
    assign sys_rst_n       = r_sys_rst_n;
    assign ready           = r_ready;
    assign locked          = r_sync2;
    assign retry_count     = r_retry;
    assign lock_loss_count = r_loss;
    assign pll_fail        = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Brief    : Self-checking bench for pll_reset_sequencer (scoreboard + vectors).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 50;
    localparam int P_STB = 8;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       ready;
    logic       locked;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;
    logic       pll_fail;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .LOCK_STABLE_CYCLES (P_STB)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pll_lock       (pll_lock),
        .pll_reset      (pll_reset),
        .sys_rst_n      (sys_rst_n),
        .ready          (ready),
        .locked         (locked),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count),
        .pll_fail       (pll_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: 0=PLLRST 1=WAIT 2=STABLE 3=RUN
    int   m_state, m_cnt, m_retry, m_loss;
    logic m_s1, m_s2;

    logic [16:0] sb[$];

    localparam logic [16:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0};

    typedef struct {
        logic       lk;
        int         n;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic       lkd;
        logic [3:0] retry;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [16:0] dut_vec();
        return {pll_reset, sys_rst_n, ready, locked, retry_count, lock_loss_count, pll_fail};
    endfunction

    function automatic logic [16:0] model_vec();
        return {m_state == 0, m_state == 3, m_state == 3, m_s2,
                4'(m_retry), 8'(m_loss), m_retry == 15};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_retry = 0; m_loss = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_edge(input logic lk);
        int ns;
        ns = m_state;
        case (m_state)
            0: begin
                if (m_cnt == P_RST - 1) begin ns = 1; m_cnt = 0; end
                else m_cnt++;
            end
            1: begin
                if (m_s2) begin ns = 2; m_cnt = 0; end
                else if (m_cnt == P_TO - 1) begin
                    ns = 0; m_cnt = 0;
                    if (m_retry < 15) m_retry++;
                end else m_cnt++;
            end
            2: begin
                if (!m_s2) begin ns = 1; m_cnt = 0; end
                else if (m_cnt == P_STB - 1) begin ns = 3; m_retry = 0; end
                else m_cnt++;
            end
            default: begin
                if (!m_s2) begin
                    ns = 0; m_cnt = 0;
                    if (m_loss < 255) m_loss++;
                end
            end
        endcase
        m_state = ns;
        m_s2    = m_s1;
        m_s1    = lk;
    endtask

    // Drive on the falling edge, predict, then compare just after the rising edge.
    task automatic step(input logic lk);
        logic [16:0] e;
        @(negedge clk);
        pll_lock = lk;
        model_edge(lk);
        sb.push_back(model_vec());
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("outputs", 32'(dut_vec()), 32'(e));
    endtask

    task automatic do_reset();
        pll_lock = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    function automatic logic lk_glitch(input int i);
        return (i >= 10) && (i != 15) && !(i >= 30 && i <= 32);
    endfunction

    initial begin
        vec_t vecs[6];
        logic prev_prst, prev_srst;
        int   rises, srst_rise1, srst_rise2, srst_fall, prst_rise2, prst_fall2, prst_falls;
        int   exp_loss;
        logic done;

        rst_n    = 1'b1;
        pll_lock = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check("reset_state", 32'(dut_vec()), 32'(RESET_VEC));

        // Clean start: lock first sampled at edge 10, release expected at edge 20.
        vecs[0] = '{1'b0, 3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2] = '{1'b0, 5,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3] = '{1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[4] = '{1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b1, 4'd0};
        vecs[5] = '{1'b1, 5,  1'b0, 1'b1, 1'b1, 1'b1, 4'd0};
        do_reset();
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].n; k++) step(vecs[v].lk);
            check("clean_vec", 32'({pll_reset, sys_rst_n, ready, locked, retry_count}),
                  32'({vecs[v].prst, vecs[v].srst, vecs[v].rdy, vecs[v].lkd, vecs[v].retry}));
        end

        // Timeout: pll_reset pulses 4 wide every 54 edges, retries saturate at 15.
        do_reset();
        prev_prst = 1'b1;
        rises     = 0;
        while (cyc < 870) begin
            step(1'b0);
            if (pll_reset && !prev_prst) begin
                rises++;
                check("prst_rise_edge", 32'(cyc), 32'(54 * rises));
            end
            if (!pll_reset && prev_prst) check("prst_fall_edge", 32'(cyc), 32'(54 * rises + 4));
            if (cyc == 809) check("fail_before_15", 32'(pll_fail), 32'd0);
            if (cyc == 810) check("retry_at_15", 32'({retry_count, pll_fail}), 32'({4'd15, 1'b1}));
            prev_prst = pll_reset;
        end
        check("retry_stays_15", 32'(retry_count), 32'd15);
        check("retries_seen", 32'(rises), 32'd16);
        repeat (20) step(1'b1);
        check("recover_after_fail", 32'({sys_rst_n, ready, retry_count, pll_fail}),
              32'({1'b1, 1'b1, 4'd0, 1'b0}));

        // Glitch in STABLE, then lock loss in RUN with re-lock.
        do_reset();
        prev_prst  = 1'b1;
        prev_srst  = 1'b0;
        srst_rise1 = -1; srst_rise2 = -1; srst_fall = -1;
        prst_rise2 = -1; prst_fall2 = -1; prst_falls = 0;
        for (int i = 1; i <= 60; i++) begin
            step(lk_glitch(i));
            if (sys_rst_n && !prev_srst) begin
                if (srst_rise1 < 0) srst_rise1 = cyc;
                else if (srst_rise2 < 0) srst_rise2 = cyc;
            end
            if (!sys_rst_n && prev_srst && srst_fall < 0) srst_fall = cyc;
            if (pll_reset && !prev_prst && prst_rise2 < 0) prst_rise2 = cyc;
            if (!pll_reset && prev_prst) begin
                prst_falls++;
                if (prst_falls == 2) prst_fall2 = cyc;
            end
            if (i == 16) check("locked_glitch_low", 32'(locked), 32'd0);
            if (i == 20) check("no_nominal_release", 32'(sys_rst_n), 32'd0);
            prev_prst = pll_reset;
            prev_srst = sys_rst_n;
        end
        check("glitch_release_edge", 32'(srst_rise1), 32'd26);
        check("loss_srst_fall_edge", 32'(srst_fall), 32'd32);
        check("loss_prst_rise_edge", 32'(prst_rise2), 32'd32);
        check("loss_prst_fall_edge", 32'(prst_fall2), 32'd36);
        check("relock_release_edge", 32'(srst_rise2), 32'd45);
        check("loss_count_1", 32'(lock_loss_count), 32'd1);

        // Asynchronous reset between edges while in RUN.
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(dut_vec()), 32'(RESET_VEC));

        // Saturation of lock_loss_count over 300 loss/re-lock cycles.
        do_reset();
        repeat (20) step(1'b1);
        check("sat_initial_run", 32'(sys_rst_n), 32'd1);
        for (int it = 0; it < 300; it++) begin
            repeat (4) step(1'b0);
            done = 1'b0;
            for (int j = 0; j < 60 && !done; j++) begin
                step(1'b1);
                if (sys_rst_n && ready) done = 1'b1;
            end
            if (!done) begin
                check("relock_timeout", 32'd0, 32'd1);
                break;
            end
            exp_loss = (it + 1 > 255) ? 255 : it + 1;
            check("sat_loss_retry", 32'({lock_loss_count, retry_count}),
                  32'({8'(exp_loss), 4'd0}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
